// File: rtl/vic_sequencer.sv
// vic_sequencer: programs a VIC's vector and enable registers, then acknowledges
// its interrupts and fetches each active vector for a downstream consumer.
module vic_sequencer #(
  parameter int          VEC_BASE  = 100,
  parameter logic [15:0] EN_MASK   = 16'hFFFF,
  parameter int          ACK_DELAY = 2,
  parameter int          VEC_PORT  = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        cs,
  output logic [4:0]  port_id,
  output logic [15:0] dout,
  output logic        write_strobe,
  output logic        read_strobe,
  input  logic [15:0] din,
  input  logic        InterruptOut,
  output logic        IntAck,
  output logic [15:0] vec,
  output logic        vec_valid,
  input  logic        vec_ready,
  output logic        cfg_done,
  output logic        overrun
);
  typedef enum logic [3:0] {
    IDLE, CFG_SETUP, CFG_STROBE, WAIT_INT, ACK_WAIT, ACK, RD_SETUP, RD_STROBE, DELIVER
  } state_t;
  localparam logic [15:0] VB = 16'(VEC_BASE);
  state_t      st;
  logic [4:0]  wi, nwi, nport;
  logic [15:0] ndata;
  logic [3:0]  cnt;
  logic        int_r, int_p, pending, rise, take;
  // write index 0..15 targets vector ports 16..31, index 16 the enable register
  always_comb begin
    nwi   = wi + 5'd1;
    nport = nwi[4] ? 5'd0 : {1'b1, nwi[3:0]};
    ndata = nwi[4] ? EN_MASK : VB + 16'(nwi);
    rise  = int_r & ~int_p;
    take  = (st == WAIT_INT) && (pending || rise);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st           <= IDLE;
      cs           <= 1'b0;
      port_id      <= '0;
      dout         <= '0;
      write_strobe <= 1'b0;
      read_strobe  <= 1'b0;
      IntAck       <= 1'b0;
      vec          <= '0;
      vec_valid    <= 1'b0;
      cfg_done     <= 1'b0;
      overrun      <= 1'b0;
      wi           <= '0;
      cnt          <= '0;
      int_r        <= 1'b0;
      int_p        <= 1'b0;
      pending      <= 1'b0;
    end else begin
      int_r   <= InterruptOut;
      int_p   <= int_r;
      pending <= take ? 1'b0 : (pending | rise);
      overrun <= overrun | (rise & pending);
      case (st)
        IDLE: if (start) begin
          st      <= CFG_SETUP;
          cs      <= 1'b1;
          port_id <= 5'd16;
          dout    <= VB;
          wi      <= '0;
        end
        CFG_SETUP: begin
          st           <= CFG_STROBE;
          write_strobe <= 1'b1;
        end
        CFG_STROBE: begin
          write_strobe <= 1'b0;
          if (wi[4]) begin
            st       <= WAIT_INT;
            cs       <= 1'b0;
            port_id  <= '0;
            dout     <= '0;
            cfg_done <= 1'b1;
          end else begin
            st      <= CFG_SETUP;
            wi      <= nwi;
            port_id <= nport;
            dout    <= ndata;
          end
        end
        WAIT_INT: if (take) begin
          st     <= (ACK_DELAY == 1) ? ACK : ACK_WAIT;
          IntAck <= (ACK_DELAY == 1);
          cnt    <= '0;
        end
        ACK_WAIT: if (cnt == 4'(ACK_DELAY - 2)) begin
          st     <= ACK;
          IntAck <= 1'b1;
        end else cnt <= cnt + 4'd1;
        ACK: begin
          st      <= RD_SETUP;
          IntAck  <= 1'b0;
          cs      <= 1'b1;
          port_id <= 5'(VEC_PORT);
        end
        RD_SETUP: begin
          st          <= RD_STROBE;
          read_strobe <= 1'b1;
        end
        RD_STROBE: begin
          st          <= DELIVER;
          read_strobe <= 1'b0;
          cs          <= 1'b0;
          port_id     <= '0;
          vec         <= din;
          vec_valid   <= 1'b1;
        end
        DELIVER: if (vec_ready) begin
          st        <= WAIT_INT;
          vec_valid <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule
